// File: rtl/operacional_multi.sv
// Multi-code door-lock controller: keypad entry, PIN table check, unlock/door timing, lockout, setup hand-off.
// Optional LOCKOUT_ESCALATE_EN: consecutive lockouts double in length (x1, x2, x4, x8 held) until a good match.
module operacional_multi #(
   parameter int PIN_DIGITS     = 4,
   parameter int NUM_PINS       = 5,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 30000,
   parameter int UNLOCK_CYCLES  = 5000,
   parameter int BIP_CYCLES     = 5000,
   parameter int ENTRY_TIMEOUT  = 10000
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   key_valid,
   input  logic [3:0]                             key_code,
   input  logic                                   sensor_de_contato,
   input  logic                                   botao_interno,
   input  logic                                   setup_end,
   input  logic [NUM_PINS*(1+4*PIN_DIGITS)-1:0]   pin_table,
   output logic                                   tranca,
   output logic                                   bip,
   output logic                                   setup_on,
   output logic                                   bcd_enable,
   output logic [4*PIN_DIGITS-1:0]                bcd_digits,
   output logic [$clog2(MAX_FAILS+1)-1:0]         fail_count,
   output logic                                   lockout,
   output logic [$clog2(NUM_PINS)-1:0]            match_idx
);

   localparam int EW = 1 + 4*PIN_DIGITS;
   localparam int DW = 4*PIN_DIGITS;
   localparam int FW = $clog2(MAX_FAILS+1);
   localparam int IW = $clog2(NUM_PINS);
   localparam logic [3:0]    PD = 4'(PIN_DIGITS);
   localparam logic [FW-1:0] MF = FW'(MAX_FAILS);

   typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCKED, DOOR_OPEN, LOCKOUT, SETUP} state_t;

   state_t state, next_state;
   logic key_prev, btn_prev;
   logic [3:0] digit_cnt;
   logic [31:0] timer, lock_timer, lock_dur;
   logic key_edge, btn_edge, key_ok, is_digit, locked;
   logic hit, check_ok, lock_expire;
   logic [IW-1:0] hit_idx;
   logic [FW-1:0] fail_next;

   assign key_edge   = key_valid & ~key_prev;
   assign btn_edge   = botao_interno & ~btn_prev;
   // The exit button takes priority over a key edge landing in the same cycle.
   assign key_ok     = key_edge & ~btn_edge & ~lockout;
   assign is_digit   = (key_code <= 4'd9);
   assign fail_next  = (fail_count == MF) ? fail_count : fail_count + 1'b1;
   assign lock_expire = lockout && (lock_timer >= lock_dur - 32'd1);
   assign check_ok   = hit && (digit_cnt == PD);

   assign locked     = !(state == UNLOCKED || state == DOOR_OPEN);
   assign tranca     = locked;
   assign bip        = (state == DOOR_OPEN) ? (timer >= 32'(BIP_CYCLES))
                                            : (locked && !sensor_de_contato);
   assign setup_on   = (state == SETUP);
   assign bcd_enable = (state == ENTRY) || (state == CHECK);

`ifdef LOCKOUT_ESCALATE_EN
   logic [1:0] esc;
   assign lock_dur = 32'(LOCKOUT_CYCLES) << esc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         esc <= 2'd0;
      else if (state == CHECK && check_ok)
         esc <= 2'd0;
      else if (lock_expire && esc != 2'd3)
         esc <= esc + 2'd1;
   end
`else
   assign lock_dur = 32'(LOCKOUT_CYCLES);
`endif

   // Scan downward so the lowest enabled matching entry is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = NUM_PINS-1; k >= 0; k--) begin
         if (pin_table[k*EW + EW - 1] && (pin_table[k*EW +: DW] == bcd_digits)) begin
            hit     = 1'b1;
            hit_idx = IW'(k);
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (btn_edge)                       next_state = UNLOCKED;
            else if (lockout && !lock_expire)   next_state = LOCKOUT;
            else if (key_ok && is_digit)        next_state = ENTRY;
         end
         ENTRY: begin
            if (btn_edge)                                   next_state = UNLOCKED;
            else if (key_ok && key_code == 4'hE)            next_state = IDLE;
            else if (key_ok && key_code == 4'hF)            next_state = CHECK;
            else if (!(key_ok && is_digit) &&
                     timer >= 32'(ENTRY_TIMEOUT - 1))       next_state = IDLE;
         end
         CHECK: begin
            if (check_ok)               next_state = (hit_idx == '0) ? SETUP : UNLOCKED;
            else if (fail_next >= MF)   next_state = LOCKOUT;
            else                        next_state = IDLE;
         end
         UNLOCKED: begin
            if (!sensor_de_contato)                         next_state = DOOR_OPEN;
            else if (timer >= 32'(UNLOCK_CYCLES - 1))       next_state = IDLE;
         end
         DOOR_OPEN: if (sensor_de_contato) next_state = IDLE;
         LOCKOUT: begin
            if (btn_edge)          next_state = UNLOCKED;
            else if (lock_expire)  next_state = IDLE;
         end
         SETUP:   if (setup_end) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The lockout flag has its own timer so an egress during lockout does not cancel it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         key_prev   <= 1'b0;
         btn_prev   <= 1'b0;
         timer      <= '0;
         lock_timer <= '0;
         bcd_digits <= '1;
         digit_cnt  <= '0;
         fail_count <= '0;
         lockout    <= 1'b0;
         match_idx  <= '0;
      end else begin
         state    <= next_state;
         key_prev <= key_valid;
         btn_prev <= botao_interno;

         if (next_state != state || (state == ENTRY && key_ok && is_digit))
            timer <= '0;
         else if (timer != '1)
            timer <= timer + 32'd1;

         if (state == CHECK || (next_state != ENTRY && next_state != CHECK)) begin
            bcd_digits <= '1;
            digit_cnt  <= '0;
         end else if (key_ok && is_digit) begin
            bcd_digits <= {bcd_digits[DW-5:0], key_code};
            if (digit_cnt != PD)
               digit_cnt <= digit_cnt + 4'd1;
         end

         if (state == CHECK) begin
            if (check_ok) begin
               match_idx  <= hit_idx;
               fail_count <= '0;
            end else begin
               fail_count <= fail_next;
            end
         end else if (lock_expire) begin
            fail_count <= '0;
         end

         if (state == CHECK && !check_ok && fail_next >= MF) begin
            lockout    <= 1'b1;
            lock_timer <= '0;
         end else if (lock_expire) begin
            lockout    <= 1'b0;
            lock_timer <= '0;
         end else if (lockout && lock_timer != '1) begin
            lock_timer <= lock_timer + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_operacional_multi.sv
// Directed bench for operacional_multi: unlock, master/setup, lockout, door/bip, rolling entry, clear, timeout, egress, reset.
module tb_operacional_multi;

   localparam int PIN_DIGITS = 4;
   localparam int NUM_PINS   = 5;
   localparam int EW         = 1 + 4*PIN_DIGITS;
`ifdef LOCKOUT_ESCALATE_EN
   localparam int LOCK2 = 400;
`else
   localparam int LOCK2 = 200;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic key_valid = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic sensor_de_contato = 1'b1;
   logic botao_interno = 1'b0;
   logic setup_end = 1'b0;
   logic [NUM_PINS*EW-1:0] pin_table;
   logic tranca, bip, setup_on, bcd_enable, lockout;
   logic [15:0] bcd_digits;
   logic [1:0] fail_count;
   logic [2:0] match_idx;

   int vectors = 0;
   int miscompares = 0;

   // Entry 3 is disabled with code 0000; entry 4 duplicates 1234 so the lowest index must win.
   assign pin_table = {1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1, 16'h4321, 1'b1, 16'h1234, 1'b1, 16'h5678};

   operacional_multi #(
      .PIN_DIGITS(4), .NUM_PINS(5), .MAX_FAILS(3), .LOCKOUT_CYCLES(200),
      .UNLOCK_CYCLES(50), .BIP_CYCLES(100), .ENTRY_TIMEOUT(80)
   ) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .sensor_de_contato(sensor_de_contato), .botao_interno(botao_interno),
      .setup_end(setup_end), .pin_table(pin_table), .tranca(tranca), .bip(bip),
      .setup_on(setup_on), .bcd_enable(bcd_enable), .bcd_digits(bcd_digits),
      .fail_count(fail_count), .lockout(lockout), .match_idx(match_idx)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] code);
      key_code  = code;
      key_valid = 1'b1;
      step(1);
      key_valid = 1'b0;
      step(1);
   endtask

   task automatic enterCode(input logic [15:0] code);
      applyStimulus(code[15:12]);
      applyStimulus(code[11:8]);
      applyStimulus(code[7:4]);
      applyStimulus(code[3:0]);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      step(2);
      checkOutput("rst_tranca", tranca, 1);
      checkOutput("rst_bip", bip, 0);
      checkOutput("rst_setup_on", setup_on, 0);
      checkOutput("rst_bcd_enable", bcd_enable, 0);
      checkOutput("rst_bcd_digits", bcd_digits, 16'hFFFF);
      checkOutput("rst_fail_count", fail_count, 0);
      checkOutput("rst_lockout", lockout, 0);
      checkOutput("rst_match_idx", match_idx, 0);
      rst = 1'b1;
      step(2);

      $display("[TB] idle E/F and forced door");
      applyStimulus(4'hF);
      applyStimulus(4'hE);
      checkOutput("idle_ef_enable", bcd_enable, 0);
      checkOutput("idle_ef_fail", fail_count, 0);
      sensor_de_contato = 1'b0;
      #1;
      checkOutput("forced_bip", bip, 1);
      sensor_de_contato = 1'b1;
      #1;
      checkOutput("forced_bip_clear", bip, 0);
      step(1);

      $display("[TB] unlock with entry 1");
      enterCode(16'h1234);
      checkOutput("entry_digits", bcd_digits, 16'h1234);
      checkOutput("entry_enable", bcd_enable, 1);
      applyStimulus(4'hF);
      checkOutput("unlock_tranca", tranca, 0);
      checkOutput("unlock_idx", match_idx, 1);
      checkOutput("unlock_blank", bcd_digits, 16'hFFFF);
      checkOutput("unlock_enable", bcd_enable, 0);
      step(49);
      checkOutput("unlock_last_cycle", tranca, 0);
      step(1);
      checkOutput("relock_tranca", tranca, 1);

      $display("[TB] master code");
      enterCode(16'h5678);
      applyStimulus(4'hF);
      checkOutput("setup_on", setup_on, 1);
      checkOutput("setup_tranca", tranca, 1);
      checkOutput("setup_idx", match_idx, 0);
      step(3);
      checkOutput("setup_hold", setup_on, 1);
      setup_end = 1'b1;
      step(1);
      setup_end = 1'b0;
      checkOutput("setup_exit", setup_on, 0);
      step(1);

      $display("[TB] lockout");
      for (int r = 1; r <= 3; r++) begin
         enterCode(16'h0000);
         applyStimulus(4'hF);
         checkOutput("fail_step", fail_count, 32'(r));
      end
      checkOutput("lock_on", lockout, 1);
      applyStimulus(4'h1);
      applyStimulus(4'h2);
      checkOutput("lock_keys_enable", bcd_enable, 0);
      checkOutput("lock_keys_digits", bcd_digits, 16'hFFFF);
      step(195);
      checkOutput("lock_last_cycle", lockout, 1);
      step(1);
      checkOutput("lock_off", lockout, 0);
      checkOutput("lock_fail_clear", fail_count, 0);

      for (int r = 1; r <= 3; r++) begin
         enterCode(16'h0000);
         applyStimulus(4'hF);
      end
      checkOutput("lock2_on", lockout, 1);
      step(LOCK2 - 1);
      checkOutput("lock2_last_cycle", lockout, 1);
      step(1);
      checkOutput("lock2_off", lockout, 0);

      $display("[TB] door open and bip");
      enterCode(16'h1234);
      applyStimulus(4'hF);
      sensor_de_contato = 1'b0;
      step(100);
      checkOutput("door_bip_early", bip, 0);
      checkOutput("door_tranca", tranca, 0);
      step(1);
      checkOutput("door_bip_on", bip, 1);
      step(49);
      checkOutput("door_bip_held", bip, 1);
      sensor_de_contato = 1'b1;
      step(1);
      checkOutput("door_close_tranca", tranca, 1);
      checkOutput("door_close_bip", bip, 0);

      $display("[TB] entry 2 then rolling window");
      enterCode(16'h4321);
      applyStimulus(4'hF);
      checkOutput("idx2", match_idx, 2);
      step(50);
      checkOutput("idx2_relock", tranca, 1);
      applyStimulus(4'h1);
      applyStimulus(4'h2);
      applyStimulus(4'h9);
      enterCode(16'h1234);
      checkOutput("roll_digits", bcd_digits, 16'h1234);
      applyStimulus(4'hF);
      checkOutput("roll_idx", match_idx, 1);
      checkOutput("roll_tranca", tranca, 0);
      step(50);

      $display("[TB] clear, short code, timeout");
      applyStimulus(4'h1);
      applyStimulus(4'h2);
      checkOutput("partial_digits", bcd_digits, 16'hFF12);
      applyStimulus(4'hE);
      checkOutput("clear_digits", bcd_digits, 16'hFFFF);
      checkOutput("clear_fail", fail_count, 0);
      applyStimulus(4'h1);
      applyStimulus(4'h2);
      applyStimulus(4'hF);
      checkOutput("short_fail", fail_count, 1);
      applyStimulus(4'h1);
      applyStimulus(4'h2);
      step(78);
      checkOutput("timeout_pending", bcd_enable, 1);
      step(1);
      checkOutput("timeout_enable", bcd_enable, 0);
      checkOutput("timeout_digits", bcd_digits, 16'hFFFF);
      checkOutput("timeout_fail", fail_count, 1);

      $display("[TB] egress button and reset");
      applyStimulus(4'h3);
      applyStimulus(4'h4);
      key_code      = 4'h5;
      key_valid     = 1'b1;
      botao_interno = 1'b1;
      step(1);
      key_valid     = 1'b0;
      botao_interno = 1'b0;
      checkOutput("btn_tranca", tranca, 0);
      checkOutput("btn_digits", bcd_digits, 16'hFFFF);
      checkOutput("btn_fail_kept", fail_count, 1);
      step(1);
      rst = 1'b0;
      #1;
      checkOutput("async_rst_tranca", tranca, 1);
      checkOutput("async_rst_fail", fail_count, 0);
      step(1);
      rst = 1'b1;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
